// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio transmitter.
package audio_pkg;

    localparam int unsigned MCLK_PER_SCLK   = 4;
    localparam int unsigned SCLK_PER_SLOT   = 32;
    localparam int unsigned SLOTS_PER_FRAME = 2;
    localparam int unsigned MCLK_PER_FRAME  = MCLK_PER_SCLK * SCLK_PER_SLOT * SLOTS_PER_FRAME;
    localparam int unsigned CNT_W           = $clog2(MCLK_PER_FRAME);

    localparam int unsigned DEFAULT_SAMPLE_W = 16;

    // Stereo pair at the default sample width; left occupies the upper half.
    typedef struct packed {
        logic [DEFAULT_SAMPLE_W-1:0] left;
        logic [DEFAULT_SAMPLE_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == PW'(DEPTH));
    assign empty      = (wr_ptr == rd_ptr);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + PW'(do_push) - PW'(do_pop);
    assign rdata      = mem[rd_ptr[AW-1:0]];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers plus a registered ready that tracks !full one cycle ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            ready <= (count_next != PW'(DEPTH));
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo Philips-I2S transmitter: MCLK = clk, SCLK = clk/4, LRCK = clk/256.
module audio_i2s_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                i2s_mclk,
    output logic                i2s_sclk,
    output logic                i2s_lrck,
    output logic                i2s_dat,
    output logic                underflow,
    output logic [15:0]         underflow_cnt
);

    import audio_pkg::*;

    localparam int unsigned IDX_W = $clog2(SAMPLE_W);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    logic             lock_meta;
    logic             locked_s;
    logic [CNT_W-1:0] cnt;
    pair_t            frame;
    pair_t            fifo_wdata;
    pair_t            fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             frame_start;
    logic [15:0]      uflow_count;
    logic [SAMPLE_W-1:0] sample;
    logic [4:0]       slot_bit;
    logic [IDX_W-1:0] bit_idx;
    logic             data_bit;

    // Clock forwarding only; no logic on this path.
    assign i2s_mclk      = clk;
    assign underflow_cnt = uflow_count;

    assign fifo_wdata  = '{left: in_left, right: in_right};
    assign fifo_push   = in_valid && in_ready && !fifo_full;
    assign frame_start = locked_s && (cnt == '1);

    sync_fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (frame_start),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ready (in_ready)
    );

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // Frame divider; parked at zero while unlocked so re-lock starts a clean frame.
    always_ff @(posedge clk) begin
        if (rst || !locked_s) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Frame register: loaded at the last cycle of each frame, zeros on underflow.
    always_ff @(posedge clk) begin
        if (rst || !locked_s) begin
            frame <= '0;
        end else if (frame_start) begin
            frame <= fifo_empty ? '0 : fifo_rdata;
        end
    end

    // Underflow pulse and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow   <= 1'b0;
            uflow_count <= '0;
        end else begin
            underflow <= frame_start && fifo_empty;
            if (frame_start && fifo_empty && (uflow_count != 16'hFFFF)) begin
                uflow_count <= uflow_count + 16'd1;
            end
        end
    end

    // Slot bit 0 is the I2S one-bit delay; bits past SAMPLE_W pad with zeros.
    always_comb begin
        sample   = cnt[7] ? frame.right : frame.left;
        slot_bit = cnt[6:2];
        bit_idx  = '0;
        data_bit = 1'b0;
        if ((slot_bit != 5'd0) && (32'(slot_bit) <= SAMPLE_W)) begin
            bit_idx  = IDX_W'(SAMPLE_W - 32'(slot_bit));
            data_bit = sample[bit_idx];
        end
    end

    // Registered serial outputs, forced low as soon as lock is lost.
    always_ff @(posedge clk) begin
        if (rst || !locked_s) begin
            i2s_sclk <= 1'b0;
            i2s_lrck <= 1'b0;
            i2s_dat  <= 1'b0;
        end else begin
            i2s_sclk <= cnt[1];
            i2s_lrck <= cnt[7];
            i2s_dat  <= data_bit;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx; timing is counted in clk edges from lock assertion.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        pll_locked;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        i2s_mclk;
    logic        i2s_sclk;
    logic        i2s_lrck;
    logic        i2s_dat;
    logic        underflow;
    logic [15:0] underflow_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .FIFO_DEPTH (4),
        .SAMPLE_W   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .i2s_mclk      (i2s_mclk),
        .i2s_sclk      (i2s_sclk),
        .i2s_lrck      (i2s_lrck),
        .i2s_dat       (i2s_dat),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected {sclk, lrck, dat} for frame position c holding pair (l, r).
    function automatic logic [2:0] exp_out(input int c, input logic [15:0] l,
                                           input logic [15:0] r);
        logic [7:0]  cc;
        logic [15:0] w;
        logic [15:0] t;
        int          b;
        logic        d;
        cc = 8'(c);
        w  = cc[7] ? r : l;
        b  = int'(cc[6:2]);
        d  = 1'b0;
        if (b >= 1 && b <= 16) begin
            t = w >> (16 - b);
            d = t[0];
        end
        return {cc[1], cc[7], d};
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        in_valid   = 1'b0;
        in_left    = '0;
        in_right   = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        pll_locked = 1'b1;
        in_valid   = 1'b0;
        tick(4);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if ({i2s_sclk, i2s_lrck, i2s_dat, underflow} !== 4'b0000 || underflow_cnt !== 16'h0)
        begin
            failures++;
            $display("FAIL reset_outputs got=%b cnt=%h exp=0000 cnt=0000",
                     {i2s_sclk, i2s_lrck, i2s_dat, underflow}, underflow_cnt);
        end
        pll_locked = 1'b0;
        rst        = 1'b0;
        tick(1);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
        end
        tick(6);
        checks++;
        if ({i2s_sclk, i2s_lrck, i2s_dat} !== 3'b000) begin
            failures++;
            $display("FAIL unlocked_idle got=%b exp=000", {i2s_sclk, i2s_lrck, i2s_dat});
        end
    endtask

    task automatic test_idle_lock();
        logic [2:0] e;
        do_reset();
        pll_locked = 1'b1;
        tick(3);
        for (int c = 0; c < 255; c++) begin
            e = exp_out(c, 16'h0, 16'h0);
            checks++;
            if ({i2s_sclk, i2s_lrck, i2s_dat} !== e || underflow !== 1'b0) begin
                failures++;
                $display("FAIL idle_frame c=%0d got=%b uf=%b exp=%b uf=0", c,
                         {i2s_sclk, i2s_lrck, i2s_dat}, underflow, e);
            end
            tick(1);
        end
        checks++;
        if (underflow !== 1'b1 || underflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL idle_underflow got=%b cnt=%0d exp=1 cnt=1", underflow, underflow_cnt);
        end
        tick(1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL idle_underflow_pulse got=%b exp=0", underflow);
        end
    endtask

    task automatic test_single_pair();
        logic [2:0] e;
        do_reset();
        in_valid = 1'b1;
        in_left  = 16'h8001;
        in_right = 16'h7FFE;
        tick(1);
        in_valid   = 1'b0;
        pll_locked = 1'b1;
        tick(259);
        for (int c = 0; c < 256; c++) begin
            e = exp_out(c, 16'h8001, 16'h7FFE);
            checks++;
            if ({i2s_sclk, i2s_lrck, i2s_dat} !== e) begin
                failures++;
                $display("FAIL single_pair c=%0d got=%b exp=%b", c,
                         {i2s_sclk, i2s_lrck, i2s_dat}, e);
            end
            tick(1);
        end
        checks++;
        if (underflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL single_pair_uflow got=%0d exp=1", underflow_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] lv [4];
        logic [15:0] rv [4];
        logic [2:0]  e;
        lv = '{16'h1234, 16'hFFFF, 16'h0001, 16'hA5A5};
        rv = '{16'hABCD, 16'h0000, 16'h8000, 16'h5A5A};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_left  = lv[i];
            in_right = rv[i];
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_before_push%0d got=%b exp=1", i, in_ready);
            end
            tick(1);
        end
        // Offer a fifth pair while full; it must be refused.
        in_left  = 16'hDEAD;
        in_right = 16'hBEEF;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_ready got=%b exp=0", in_ready);
        end
        tick(1);
        in_valid   = 1'b0;
        pll_locked = 1'b1;
        tick(257);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_before_pop got=%b exp=0", in_ready);
        end
        tick(1);
        checks++;
        if (in_ready !== 1'b1 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_after_pop got=%b uf=%b exp=1 uf=0", in_ready, underflow);
        end
        tick(1);
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 256; c++) begin
                e = exp_out(c, lv[f], rv[f]);
                checks++;
                if ({i2s_sclk, i2s_lrck, i2s_dat} !== e) begin
                    failures++;
                    $display("FAIL b2b_frame%0d c=%0d got=%b exp=%b", f, c,
                             {i2s_sclk, i2s_lrck, i2s_dat}, e);
                end
                tick(1);
            end
        end
        checks++;
        if (underflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL b2b_uflow_after_drain got=%0d exp=1", underflow_cnt);
        end
    endtask

    task automatic test_push_at_frame_start();
        logic [2:0] e;
        do_reset();
        pll_locked = 1'b1;
        tick(257);
        in_valid = 1'b1;
        in_left  = 16'h00FF;
        in_right = 16'hFF00;
        tick(1);
        in_valid = 1'b0;
        checks++;
        if (underflow !== 1'b1 || underflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL edge_push_uflow got=%b cnt=%0d exp=1 cnt=1", underflow, underflow_cnt);
        end
        tick(1);
        for (int c = 0; c < 256; c++) begin
            checks++;
            if (i2s_dat !== 1'b0) begin
                failures++;
                $display("FAIL edge_push_zero_frame c=%0d got=%b exp=0", c, i2s_dat);
            end
            tick(1);
        end
        for (int c = 0; c < 256; c++) begin
            e = exp_out(c, 16'h00FF, 16'hFF00);
            checks++;
            if ({i2s_sclk, i2s_lrck, i2s_dat} !== e) begin
                failures++;
                $display("FAIL edge_push_frame c=%0d got=%b exp=%b", c,
                         {i2s_sclk, i2s_lrck, i2s_dat}, e);
            end
            tick(1);
        end
    endtask

    task automatic test_lock_loss();
        logic [15:0] lv [3];
        logic [15:0] rv [3];
        logic [2:0]  e;
        lv = '{16'h1357, 16'hC001, 16'h0F0F};
        rv = '{16'h2468, 16'h4003, 16'hF0F0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_left  = lv[i];
            in_right = rv[i];
            tick(1);
        end
        in_valid   = 1'b0;
        pll_locked = 1'b1;
        tick(358);
        pll_locked = 1'b0;
        tick(3);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({i2s_sclk, i2s_lrck, i2s_dat} !== 3'b000) begin
                failures++;
                $display("FAIL lock_loss_silent i=%0d got=%b exp=000", i,
                         {i2s_sclk, i2s_lrck, i2s_dat});
            end
            tick(1);
        end
        pll_locked = 1'b1;
        tick(3);
        // First frame after re-lock is zero data, then the retained pairs in order.
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 256; c++) begin
                e = (f == 0) ? exp_out(c, 16'h0, 16'h0) : exp_out(c, lv[f], rv[f]);
                checks++;
                if ({i2s_sclk, i2s_lrck, i2s_dat} !== e) begin
                    failures++;
                    $display("FAIL relock_frame%0d c=%0d got=%b exp=%b", f, c,
                             {i2s_sclk, i2s_lrck, i2s_dat}, e);
                end
                tick(1);
            end
        end
        checks++;
        if (underflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL relock_uflow got=%0d exp=1", underflow_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt [4];
        exp_cnt = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        do_reset();
        force dut.uflow_count = 16'hFFFD;
        tick(1);
        release dut.uflow_count;
        tick(1);
        checks++;
        if (underflow_cnt !== 16'hFFFD) begin
            failures++;
            $display("FAIL sat_preload got=%h exp=fffd", underflow_cnt);
        end
        pll_locked = 1'b1;
        tick(258);
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (underflow !== 1'b1 || underflow_cnt !== exp_cnt[f]) begin
                failures++;
                $display("FAIL sat_frame%0d got=%b cnt=%h exp=1 cnt=%h", f, underflow,
                         underflow_cnt, exp_cnt[f]);
            end
            if (f < 3) begin
                tick(256);
            end
        end
        tick(1);
        checks++;
        if (underflow !== 1'b0 || underflow_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%b cnt=%h exp=0 cnt=ffff", underflow, underflow_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        in_valid   = 1'b0;
        in_left    = '0;
        in_right   = '0;
        test_reset();
        test_idle_lock();
        test_single_pair();
        test_back_to_back();
        test_push_at_frame_start();
        test_lock_loss();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo I2S transmitter clocked directly from the 12.288 MHz audio clock produced by the core's audio PLL. It accepts 16-bit left/right sample pairs over a valid/ready handshake and buffers them in a small FIFO. It serializes them as standard Philips I2S with MCLK = clk, SCLK = clk/4 (3.072 MHz) and LRCK = clk/256 (48 kHz). Output is held silent until the PLL lock indication is stable.

## Interface
Parameters:
- FIFO_DEPTH, 4: sample-pair FIFO entries; power of two, ≥2.
- SAMPLE_W, 16: bits per channel sample; range 8..31.

Ports:
- clk  in  1  12.288 MHz audio clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- pll_locked  in  1  asynchronous PLL lock flag; synchronized internally.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  FIFO can accept; registered, equals !full.
- in_left  in  SAMPLE_W  left sample, two's complement.
- in_right  in  SAMPLE_W  right sample, two's complement.
- i2s_mclk  out  1  forwarded clk (clock-forwarding buffer, not logic).
- i2s_sclk  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left.
- i2s_dat  out  1  serial data, MSB first.
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- underflow_cnt  out  16  saturating count of underflows.

## Operation
- Lock synchronizer: 2-flop synchronizer on pll_locked, giving locked_s.
- Divider: 8-bit counter cnt.
  - While locked_s = 0, cnt is held at 0.
  - Otherwise cnt increments every cycle and wraps 255→0; one wrap is one frame.
- Frame load: on every cycle where the counter is enabled and cnt = 255, pop the FIFO into the frame register {L, R}.
  - If the FIFO is empty, load zeros, pulse underflow and increment underflow_cnt. The counter saturates at 0xFFFF.
- Serialization: slot bit b = cnt[6:2] (0..31); channel = cnt[7].
  - Data bit = sample[SAMPLE_W-b] for 1 ≤ b ≤ SAMPLE_W, otherwise 0.
  - This gives the one-SCLK I2S delay after the LRCK edge and zero padding to the 32-bit slot.
- Outputs, all registered from the current cnt:
  - i2s_sclk = cnt[1]
  - i2s_lrck = cnt[7]
  - i2s_dat = data bit
  - Data therefore changes only when i2s_sclk falls and is stable at the rising edge.
- Loss of lock mid-frame: when locked_s drops, cnt returns to 0 on the next cycle.
  - sclk, lrck and dat go to 0.
  - The frame register is cleared.
  - FIFO contents are retained.
  - On re-lock the first frame starts at cnt = 0 with zero data, and the first pop occurs at cnt = 255.
- FIFO:
  - A push occurs when in_valid && in_ready.
  - Push and pop in the same cycle are both honoured when the FIFO is neither empty nor full.
  - Push into an empty FIFO on the same cycle as a frame-load pop: the pop sees empty (no bypass), so underflow is counted and the pushed pair remains in the FIFO.
  - Push into a full FIFO is impossible because in_ready = 0.
  - FIFO accepts pushes regardless of locked_s.

## Timing
- Reset values:
  - cnt = 0, FIFO empty, frame register 0.
  - in_ready = 0 during reset and 1 on the first cycle after rst deasserts.
  - i2s_sclk, i2s_lrck, i2s_dat, underflow and underflow_cnt are all 0.
- Lock latency: 2 cycles from pll_locked rising to locked_s; cnt starts counting the next cycle.
- Frame rate: 256 clk cycles per frame (48.000 kHz); i2s_sclk period is 4 clk cycles, 50% duty.
- Data latency: a pair pushed at cycle t is loaded at the first enabled cnt = 255 strictly after t.
  - Its left MSB appears on i2s_dat 1 + 4 cycles later: 1 cycle for the frame-start register, then one SCLK period for the I2S delay.
- in_ready deasserts in the cycle after the push that fills the FIFO, and reasserts in the cycle after a pop from full.

## Structure
- Shared package audio_pkg: MCLK_PER_SCLK = 4, SCLK_PER_SLOT = 32, SLOTS_PER_FRAME = 2, and the stereo sample pair type (left, right fields).
- Sub-module sync_fifo (WIDTH = 2*SAMPLE_W, DEPTH = FIFO_DEPTH):
  - Single-clock FIFO with full/empty flags.
  - Pointers are one bit wider than the address to distinguish full from empty.
- The top level contains the synchronizer, divider, frame register, serializer and underflow counter.

## Test plan
- Reset, then lock high with no pushes → 2+1 cycles later cnt runs; first cnt = 255 gives underflow pulse and underflow_cnt = 1; dat stays 0; LRCK period = 256 cycles, SCLK period = 4 cycles.
- Push L=0x8001, R=0x7FFE, then lock → next frame shows LRCK low with dat bits 1,0…0,1 on slot bits 1–16, then LRCK high with 0,1…1,0; bits 0 and 17–31 are 0.
- Push 4 pairs back-to-back with lock low → in_ready low after the 4th; on lock the pairs play in order across 4 frames; in_ready rises the cycle after the first pop.
- Push into an empty FIFO exactly at cnt = 255 → underflow counted; that pair plays in the following frame.
- Drop pll_locked mid-frame (cnt = 100) → outputs 0 within 3 cycles; FIFO count unchanged; re-lock restarts at cnt = 0 with a zero frame.
- Force 65 540 underflows (or preload the counter) → underflow_cnt saturates at 0xFFFF while the underflow pulse continues.
